stash_browser: RTL

//  Read-side controller for the sample Stash. It turns a raw "next" push-button and an optional

---
 rtl/stash_browser.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stash_browser.sv
// stash_browser: read-side controller for the sample Stash.
// Optional auto-scroll build: define STASH_AUTO_SCROLL_EN.
module stash_browser #(
  parameter int DEPTH        = 5,
  parameter int DEBOUNCE_CYC = 4,
  parameter int AUTO_PERIOD  = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_auto,
  input  logic             stash_wr,
  input  logic [7:0]       stash_sample,
  output logic             next_sample,
  output logic [PTR_W-1:0] index,
  output logic [7:0]       shown_sample,
  output logic             auto_on
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AP_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(DEPTH - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_CNT = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CNT   = 2'd3;

`ifdef STASH_AUTO_SCROLL_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync_q1;
  logic [NB-1:0]   sync_q2;
  logic [NB-1:0]   db_req;
  logic [1:0]      db_st  [NB];
  logic [DB_W-1:0] db_cnt [NB];
  logic            auto_req;
  logic            req_any;
  logic            pending;

`ifdef STASH_AUTO_SCROLL_EN
  assign btn_raw = {btn_auto, btn_next};
`else
  logic            unused_btn_auto;
  logic [AP_W-1:0] unused_period;
  assign btn_raw         = btn_next;
  assign unused_btn_auto = btn_auto;
  assign unused_period   = AP_LAST;
`endif

  // two-flop synchronizers for the raw buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // debouncer FSM per button; count tracks consecutive stable cycles
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (reset) begin
        db_st[i]  <= IDLE;
        db_cnt[i] <= '0;
      end else begin
        unique case (db_st[i])
          IDLE: begin
            db_cnt[i] <= '0;
            if (sync_q2[i]) db_st[i] <= PRESS_CNT;
          end
          PRESS_CNT: begin
            if (!sync_q2[i]) begin
              db_st[i]  <= IDLE;
              db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
              db_st[i]  <= HELD;
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
          HELD: begin
            db_cnt[i] <= '0;
            if (!sync_q2[i]) db_st[i] <= REL_CNT;
          end
          REL_CNT: begin
            if (sync_q2[i]) begin
              db_st[i]  <= HELD;
              db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
              db_st[i]  <= IDLE;
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
          default: begin
            db_st[i]  <= IDLE;
            db_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  // one request on the cycle a press is accepted
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      db_req[i] = (db_st[i] == PRESS_CNT) && sync_q2[i] &&
                  (db_cnt[i] == DB_LAST);
    end
  end

`ifdef STASH_AUTO_SCROLL_EN
  logic            auto_q;
  logic [AP_W-1:0] ap_cnt;

  // auto-scroll toggle and period counter (cleared on every toggle)
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q <= 1'b0;
      ap_cnt <= '0;
    end else if (db_req[NB-1]) begin
      auto_q <= ~auto_q;
      ap_cnt <= '0;
    end else if (auto_q) begin
      ap_cnt <= (ap_cnt == AP_LAST) ? '0 : ap_cnt + 1'b1;
    end
  end

  assign auto_req = auto_q && (ap_cnt == AP_LAST);
  assign auto_on  = auto_q;
`else
  assign auto_req = 1'b0;
  assign auto_on  = 1'b0;
`endif

  assign req_any     = db_req[0] | auto_req;
  assign next_sample = pending & ~stash_wr & ~reset;

  // pending merge, index mirror and display register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 1'b0;
      index        <= '0;
      shown_sample <= '0;
    end else begin
      shown_sample <= stash_sample;
      pending      <= (pending & ~next_sample) | req_any;
      if (next_sample)
        index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end
  end

endmodule
